deserializer_fsm: RTL and testbench
===================================

Name: deserializer_fsm

Overview:
Downstream neighbour of the FIR serializer. Consumes an LSB-first serial bit stream under a valid/ready handshake and assembles LENGTH-bit parallel words. Presents each word on a registered parallel output with its own valid/ready handshake toward the next FIR stage. Supports a synchronous flush that discards a partially assembled word.

Parameters:
LENGTH, 24, bits per word; legal range 2..64
CNT_BITS, $clog2(LENGTH)+1, bit-counter width (derived; not overridden)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_en  in  1  clock enable; when 0 all state, counter and outputs hold
i_flush  in  1  synchronous abort of the partial word
i_din  in  1  serial data bit, LSB of word first
i_din_valid  in  1  upstream bit valid
o_ready  out  1  combinational: ready to accept a bit = (state==COLLECT) && i_en && !i_flush
ov_dout  out  LENGTH  assembled word (registered)
o_dout_valid  out  1  ov_dout holds a complete word (registered)
i_ready  in  1  downstream accepts ov_dout
o_word_done  out  1  one-cycle pulse (registered) on the edge a word completes

Behaviour:
- Reset (i_rst=1 at an edge, overrides i_en): state=COLLECT, counter=0, shift_reg=0, ov_dout=0, o_dout_valid=0, o_word_done=0. Reset mid-word discards the partial word and any held output.
- Bit transfer: occurs at an edge where i_en && i_din_valid && o_ready. Nothing else advances the counter.
- Bit assembly: on transfer, shift_reg <= {i_din, shift_reg[LENGTH-1:1]}. After LENGTH transfers, the first bit is at bit 0.
- States: COLLECT, HOLD. Encodings come from the shared package. Any illegal state goes to COLLECT with counter=0.
- COLLECT:
  - On a transfer with counter < LENGTH-1: counter+1.
  - On a transfer with counter == LENGTH-1: ov_dout <= {i_din, shift_reg[LENGTH-1:1]}, o_dout_valid <= 1, o_word_done <= 1 for that cycle only, counter <= 0, go to HOLD.
  - Latency: the last bit is accepted at edge N; the word is visible and valid after edge N.
- HOLD:
  - o_ready=0, so upstream stalls.
  - ov_dout and o_dout_valid are stable until an edge with i_en && i_ready.
  - At that edge: o_dout_valid <= 0, go to COLLECT. The next bit can be accepted in the following cycle, so minimum word period is LENGTH+1 cycles.
- Flush (i_en && i_flush, no reset):
  - In COLLECT: counter=0, shift_reg=0. No bit accepted that cycle, because o_ready is forced 0.
  - In HOLD: no effect. A completed word is never discarded by flush.
- i_en=0: every register holds and o_ready=0. i_ready and i_din_valid are ignored.
- o_word_done deasserts on the next enabled edge. It holds its value while i_en=0.
- Upstream misuse (i_din_valid dropping mid-word) simply pauses assembly. There is no timeout.

Decomposition:
- Shared package/header fir_pkg: state encodings ST_COLLECT=1'b0, ST_HOLD=1'b1; a function for counter width.
- Single module. There is no natural sub-module; the counter and shift register are inline.

Test Plan:
- Basic (LENGTH=8): bits of 0xA5 LSB-first, i_din_valid=1 continuously, i_ready=1 → ov_dout=0xA5 and o_dout_valid=1 one cycle after the 8th transfer; o_word_done pulses once; o_ready low for exactly 1 cycle.
- Back-pressure: two words 0x3C then 0xC3 with i_ready=0 for 5 cycles after the first completes → ov_dout stays 0x3C and o_ready stays 0 for those 5 cycles; the second word arrives intact as 0xC3.
- Gaps: 0x81 with i_din_valid toggling 1/0 each cycle → word still 0x81; completes 16 cycles after start.
- Flush mid-word: 3 bits of garbage, then i_flush for 1 cycle, then 0x5A → output is 0x5A only, and no word is emitted for the garbage bits.
- Reset and enable:
  - Assert i_rst after 4 bits → all outputs 0, then a fresh 0xFF assembles correctly.
  - Drop i_en for 3 cycles in both COLLECT and HOLD → no state, counter or output change, and o_ready=0 throughout.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR-chain state encodings and width helper
package fir_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/deserializer_fsm.sv
// rtl/deserializer_fsm.sv - LSB-first serial-to-parallel word assembler with handshakes
module deserializer_fsm
    import fir_pkg::*;
#(
    parameter int LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_word_done
);

    localparam int CNT_BITS = cnt_width(LENGTH);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LENGTH - 1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [LENGTH-1:0]   shift_q, shift_d;
    logic [LENGTH-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                word_done_q, word_done_d;
    logic                xfer;
    logic [LENGTH-1:0]   shift_next;

    assign o_ready      = (state_q == ST_COLLECT) && i_en && !i_flush;
    assign xfer         = i_en && i_din_valid && o_ready;
    assign shift_next   = {i_din, shift_q[LENGTH-1:1]};
    assign ov_dout      = dout_q;
    assign o_dout_valid = dout_valid_q;
    assign o_word_done  = word_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        word_done_d  = word_done_q;
        // With i_en low everything, including the done pulse, is frozen.
        if (i_en) begin
            word_done_d = 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (i_flush) begin
                        cnt_d   = '0;
                        shift_d = '0;
                    end else if (xfer) begin
                        shift_d = shift_next;
                        if (cnt_q == CNT_LAST) begin
                            dout_d       = shift_next;
                            dout_valid_d = 1'b1;
                            word_done_d  = 1'b1;
                            cnt_d        = '0;
                            state_d      = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        dout_valid_d = 1'b0;
                        state_d      = ST_COLLECT;
                    end
                end
                default: begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_COLLECT;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            word_done_q  <= word_done_d;
        end
    end

endmodule

// File: tb/tb_deserializer_fsm.sv
// tb/tb_deserializer_fsm.sv - scoreboard bench for deserializer_fsm at LENGTH=8
module tb_deserializer_fsm;

    localparam int LENGTH = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_en = 1'b1;
    logic              i_flush = 1'b0;
    logic              i_din = 1'b0;
    logic              i_din_valid = 1'b0;
    logic              i_ready = 1'b1;
    logic              o_ready;
    logic [LENGTH-1:0] ov_dout;
    logic              o_dout_valid;
    logic              o_word_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [LENGTH-1:0] exp_q[$];
    logic prev_valid = 1'b0;

    deserializer_fsm #(.LENGTH(LENGTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_flush     (i_flush),
        .i_din       (i_din),
        .i_din_valid (i_din_valid),
        .o_ready     (o_ready),
        .ov_dout     (ov_dout),
        .o_dout_valid(o_dout_valid),
        .i_ready     (i_ready),
        .o_word_done (o_word_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: each new word (valid rising) is matched to the oldest expectation.
    always @(negedge i_clk) begin
        if (!i_rst && o_dout_valid === 1'b1 && prev_valid == 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: actual=%0h required=none", ov_dout);
            end else begin
                check("word_data", 64'(ov_dout), 64'(exp_q.pop_front()));
                check("word_done_pulse", 64'(o_word_done), 64'd1);
            end
        end
        prev_valid = (o_dout_valid === 1'b1);
    end

    task automatic xfer_bit(input logic b);
        int tries;
        tries = 0;
        i_din = b;
        i_din_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && tries < 50) begin
            @(negedge i_clk);
            tries++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: actual=0 required=1");
        end
        @(posedge i_clk);
        #1;
        i_din_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [LENGTH-1:0] w, input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                i_din_valid = 1'b0;
                @(posedge i_clk);
                #1;
            end
            xfer_bit(w[i]);
        end
    endtask

    task automatic idle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int start;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_dout", 64'(ov_dout), 64'd0);
        check("reset_valid", 64'(o_dout_valid), 64'd0);
        check("reset_done", 64'(o_word_done), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd1);
        idle();

        // Basic word with continuous valid and a ready consumer
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 0, 7, 1'b0);
        @(negedge i_clk);
        check("basic_valid", 64'(o_dout_valid), 64'd1);
        check("basic_ready_low", 64'(o_ready), 64'd0);
        check("basic_done", 64'(o_word_done), 64'd1);
        idle();
        @(negedge i_clk);
        check("basic_ready_back", 64'(o_ready), 64'd1);
        check("basic_done_clear", 64'(o_word_done), 64'd0);
        check("basic_valid_clear", 64'(o_dout_valid), 64'd0);
        idle();

        // Back-pressure: hold the first word for 5 cycles
        i_ready = 1'b0;
        exp_q.push_back(8'h3C);
        send_bits(8'h3C, 0, 7, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check("bp_hold_dout", 64'(ov_dout), 64'h3C);
            check("bp_hold_ready", 64'(o_ready), 64'd0);
            check("bp_hold_valid", 64'(o_dout_valid), 64'd1);
            idle();
        end
        i_ready = 1'b1;
        exp_q.push_back(8'hC3);
        send_bits(8'hC3, 0, 7, 1'b0);
        idle();

        // Gapped valid
        exp_q.push_back(8'h81);
        start = cyc;
        send_bits(8'h81, 0, 7, 1'b1);
        check("gap_cycles", 64'(cyc - start), 64'd16);
        idle();

        // Flush after 3 garbage bits
        send_bits(8'h05, 0, 2, 1'b0);
        i_flush = 1'b1;
        i_din = 1'b1;
        i_din_valid = 1'b1;
        @(negedge i_clk);
        check("flush_ready_low", 64'(o_ready), 64'd0);
        idle();
        i_flush = 1'b0;
        i_din_valid = 1'b0;
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 0, 7, 1'b0);
        idle();

        // Reset mid-word
        send_bits(8'h0F, 0, 3, 1'b0);
        i_rst = 1'b1;
        idle();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_dout", 64'(ov_dout), 64'd0);
        check("rst_valid", 64'(o_dout_valid), 64'd0);
        check("rst_done", 64'(o_word_done), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        idle();
        exp_q.push_back(8'hFF);
        send_bits(8'hFF, 0, 7, 1'b0);
        idle();

        // Enable dropped in COLLECT and in HOLD
        i_ready = 1'b0;
        exp_q.push_back(8'h96);
        send_bits(8'h96, 0, 2, 1'b0);
        i_en = 1'b0;
        i_din = 1'b0;
        i_din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("en_collect_ready", 64'(o_ready), 64'd0);
            check("en_collect_valid", 64'(o_dout_valid), 64'd0);
            idle();
        end
        i_en = 1'b1;
        i_din_valid = 1'b0;
        send_bits(8'h96, 3, 7, 1'b0);
        i_en = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("en_hold_valid", 64'(o_dout_valid), 64'd1);
            check("en_hold_dout", 64'(ov_dout), 64'h96);
            check("en_hold_ready", 64'(o_ready), 64'd0);
            check("en_hold_done", 64'(o_word_done), 64'd1);
            idle();
        end
        i_en = 1'b1;
        idle();
        @(negedge i_clk);
        check("en_release_valid", 64'(o_dout_valid), 64'd0);
        check("en_release_done", 64'(o_word_done), 64'd0);
        check("en_release_ready", 64'(o_ready), 64'd1);

        repeat (5) idle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
